// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared constants for the multiplexed 7-segment scan driver:
//   - GLYPH_ROM : 16-entry hex font, active-high, bit0=a .. bit6=g
//   - SEG_OFF   : all-segments-off pattern (active-high domain)
//   - SEG_A..SEG_G, SEG_DP : segment bit positions inside the 8-bit SEG bus
//   - div_cnt_width / dig_idx_width : counter widths derived from parameters
package seg7_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] SEG_OFF = 8'h00;

  // Hex font 0..F (b and d are lower case so they differ from 8 and 0).
  localparam logic [6:0] GLYPH_ROM [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Width of a counter running 0..clk_div-1 (never narrower than 1 bit).
  function automatic int div_cnt_width(input int clk_div);
    return (clk_div <= 1) ? 1 : $clog2(clk_div);
  endfunction

  // Width of the digit index running 0..num_digits-1 (never narrower than 1 bit).
  function automatic int dig_idx_width(input int num_digits);
    return (num_digits <= 1) ? 1 : $clog2(num_digits);
  endfunction

endpackage

// File: rtl/seg7_glyph_lut.sv
// seg7_glyph_lut
// Combinational nibble-to-segment decoder.
// Ports:
//   nibble_i  [3:0]  hex digit to render
//   blank_i          1 = force segments a..g off (dp still follows dp_i)
//   dp_i             decimal point
//   pattern_o [7:0]  active-high pattern, bit0=a .. bit6=g, bit7=dp
module seg7_glyph_lut
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  input  logic       dp_i,
  output logic [7:0] pattern_o
);

  // Font lookup with blanking; dp is independent of blanking.
  always_comb begin
    pattern_o = SEG_OFF;
    if (blank_i) begin
      pattern_o[SEG_G:SEG_A] = 7'h00;
    end else begin
      pattern_o[SEG_G:SEG_A] = GLYPH_ROM[nibble_i];
    end
    pattern_o[SEG_DP] = dp_i;
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Multiplexed N-digit 7-segment driver. Scans one digit per CLK_DIV-cycle
// slot, with a blank gap at the start of every slot to prevent ghosting.
// New data is captured into a shadow buffer on load_i and promoted to the
// displayed (active) buffer only at the frame wrap, so a frame never tears.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   value_i [4*N-1:0]       hex value, nibble i -> digit i (digit 0 = LSD)
//   dots_i  [N-1:0]         decimal point per digit
//   load_i                  capture value_i/dots_i into the shadow buffer
//   lzb_i                   leading-zero blanking, applied live
//   bright_i [2:0]          brightness (only with SEG7_DIMMING_EN defined)
//   seg_o [7:0]             segments, bit0=a .. bit6=g, bit7=dp
//   dig_o [N-1:0]           one-hot digit enable
//   pending_o               shadow holds data not yet displayed
//   frame_done_o            one-cycle pulse when the scan wraps to digit 0
// Optional feature macro: SEG7_DIMMING_EN (adds bright_i, shortens the lit window).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int CLK_DIV     = 1000,
  parameter int BLANK_CYC   = 2,
  parameter bit SEG_ACT_LOW = 1'b0,
  parameter bit DIG_ACT_LOW = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dots_i,
  input  logic                    load_i,
  input  logic                    lzb_i,
`ifdef SEG7_DIMMING_EN
  input  logic [2:0]              bright_i,
`endif
  output logic [7:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   dig_o,
  output logic                    pending_o,
  output logic                    frame_done_o
);

  localparam int DIV_W = div_cnt_width(CLK_DIV);
  localparam int IDX_W = dig_idx_width(NUM_DIGITS);
  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:0]            SEG_IDLE = SEG_ACT_LOW ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_IDLE = DIG_ACT_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]        dig_idx_q, dig_idx_d;
  logic [4*NUM_DIGITS-1:0] active_val_q, active_val_d;
  logic [NUM_DIGITS-1:0]   active_dots_q, active_dots_d;
  logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0]   shadow_dots_q, shadow_dots_d;
  logic                    pending_q, pending_d;
  logic                    frame_done_q, frame_done_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;

  logic                    tick_s;
  logic                    wrap_s;
  logic [NUM_DIGITS-1:0]   lz_blank_s;
  logic [3:0]              cur_nib_s;
  logic                    cur_blank_s;
  logic                    cur_dp_s;
  logic [7:0]              glyph_s;
  logic [31:0]             win_end_s;
  logic                    in_window_s;
  logic [7:0]              seg_raw_s;
  logic [NUM_DIGITS-1:0]   dig_raw_s;

  assign tick_s = (div_cnt_q == DIV_LAST);
  assign wrap_s = tick_s && (dig_idx_q == IDX_LAST);

  // Prescaler and digit index.
  always_comb begin
    div_cnt_d = tick_s ? '0 : div_cnt_q + 1'b1;
    dig_idx_d = dig_idx_q;
    if (tick_s) begin
      dig_idx_d = (dig_idx_q == IDX_LAST) ? '0 : dig_idx_q + 1'b1;
    end else begin
      dig_idx_d = dig_idx_q;
    end
  end

  // Shadow/active buffering. A load coinciding with the wrap tick bypasses
  // the shadow so the newest data is what the next frame shows.
  always_comb begin
    shadow_val_d  = shadow_val_q;
    shadow_dots_d = shadow_dots_q;
    active_val_d  = active_val_q;
    active_dots_d = active_dots_q;
    pending_d     = pending_q;
    if (load_i) begin
      shadow_val_d  = value_i;
      shadow_dots_d = dots_i;
    end else begin
      shadow_val_d  = shadow_val_q;
      shadow_dots_d = shadow_dots_q;
    end
    if (wrap_s) begin
      if (load_i) begin
        active_val_d  = value_i;
        active_dots_d = dots_i;
      end else if (pending_q) begin
        active_val_d  = shadow_val_q;
        active_dots_d = shadow_dots_q;
      end else begin
        active_val_d  = active_val_q;
        active_dots_d = active_dots_q;
      end
      pending_d = 1'b0;
    end else if (load_i) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end
    frame_done_d = wrap_s;
  end

  // Leading-zero mask: digit i>0 blanks when all nibbles from the top down to i are zero.
  always_comb begin
    logic zero_run;
    zero_run   = 1'b1;
    lz_blank_s = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run & (active_val_q[4*i +: 4] == 4'h0);
      lz_blank_s[i] = (i > 0) ? zero_run : 1'b0;
    end
  end

  assign cur_nib_s   = active_val_q[{dig_idx_q, 2'b00} +: 4];
  assign cur_blank_s = lzb_i & lz_blank_s[dig_idx_q];
  assign cur_dp_s    = active_dots_q[dig_idx_q];

  seg7_glyph_lut u_lut (
    .nibble_i  (cur_nib_s),
    .blank_i   (cur_blank_s),
    .dp_i      (cur_dp_s),
    .pattern_o (glyph_s)
  );

  // Lit window inside the slot; dimming trims its tail in eighths.
  always_comb begin
`ifdef SEG7_DIMMING_EN
    win_end_s = 32'(BLANK_CYC)
              + ((32'(CLK_DIV - BLANK_CYC) * (32'(bright_i) + 32'd1)) / 32'd8);
`else
    win_end_s = 32'(CLK_DIV);
`endif
    in_window_s = (32'(div_cnt_q) >= 32'(BLANK_CYC)) && (32'(div_cnt_q) < win_end_s);
  end

  // Output pattern selection, polarity applied last.
  always_comb begin
    seg_raw_s = SEG_OFF;
    dig_raw_s = '0;
    if (in_window_s) begin
      seg_raw_s            = glyph_s;
      dig_raw_s[dig_idx_q] = 1'b1;
    end else begin
      seg_raw_s = SEG_OFF;
      dig_raw_s = '0;
    end
    seg_d = SEG_ACT_LOW ? ~seg_raw_s : seg_raw_s;
    dig_d = DIG_ACT_LOW ? ~dig_raw_s : dig_raw_s;
  end

  // State and output registers; reset discards any pending shadow data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt_q     <= '0;
      dig_idx_q     <= '0;
      active_val_q  <= '0;
      active_dots_q <= '0;
      shadow_val_q  <= '0;
      shadow_dots_q <= '0;
      pending_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      seg_q         <= SEG_IDLE;
      dig_q         <= DIG_IDLE;
    end else begin
      div_cnt_q     <= div_cnt_d;
      dig_idx_q     <= dig_idx_d;
      active_val_q  <= active_val_d;
      active_dots_q <= active_dots_d;
      shadow_val_q  <= shadow_val_d;
      shadow_dots_q <= shadow_dots_d;
      pending_q     <= pending_d;
      frame_done_q  <= frame_done_d;
      seg_q         <= seg_d;
      dig_q         <= dig_d;
    end
  end

  assign seg_o        = seg_q;
  assign dig_o        = dig_q;
  assign pending_o    = pending_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed testbench for seg7_scan_driver (NUM_DIGITS=4, CLK_DIV=8, BLANK_CYC=2).
// Two instances share stimulus: dut_h (active-high outputs) and dut_l
// (active-low SEG and DIG). Inputs change and outputs are sampled on the
// falling edge. cyc counts rising edges since reset release, so after edge t
// the scan state is div=t%8, dig=(t/8)%4 and the registered outputs reflect
// the state one edge earlier. Digit d is observed at frame phase 8*d+5.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dots = 4'b0000;
  logic        load = 1'b0;
  logic        lzb = 1'b0;
`ifdef SEG7_DIMMING_EN
  logic [2:0]  bright = 3'd7;
`endif

  logic [7:0] seg_h, seg_l;
  logic [3:0] dig_h, dig_l;
  logic       pend_h, pend_l, fd_h, fd_l;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  seg7_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(8), .BLANK_CYC(2),
                     .SEG_ACT_LOW(1'b0), .DIG_ACT_LOW(1'b0)) dut_h (
    .clk_i(clk), .rst_i(rst), .value_i(value), .dots_i(dots), .load_i(load), .lzb_i(lzb),
`ifdef SEG7_DIMMING_EN
    .bright_i(bright),
`endif
    .seg_o(seg_h), .dig_o(dig_h), .pending_o(pend_h), .frame_done_o(fd_h)
  );

  seg7_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(8), .BLANK_CYC(2),
                     .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b1)) dut_l (
    .clk_i(clk), .rst_i(rst), .value_i(value), .dots_i(dots), .load_i(load), .lzb_i(lzb),
`ifdef SEG7_DIMMING_EN
    .bright_i(bright),
`endif
    .seg_o(seg_l), .dig_o(dig_l), .pending_o(pend_l), .frame_done_o(fd_l)
  );

  always #5 clk = ~clk;

  // Bench-side edge counter since reset release.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Advance to the next falling edge whose frame phase equals p.
  task automatic wait_phase(input int p);
    int guard = 0;
    @(negedge clk);
    while ((cyc % 32) != p && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if ((cyc % 32) != p) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_phase: phase %0d, wanted %0d", cyc % 32, p);
    end
  endtask

  // One-cycle LOAD strobe issued at frame phase 13 (digit 1, div 5).
  task automatic load_mid_frame(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dots  = d;
    wait_phase(13);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset;
    logic [3:0] ed;
    logic [7:0] es;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++; if (seg_h !== 8'h00) begin n_bad++; $display("FAIL reset_seg_h: got %h expected 00", seg_h); end
      n_cmp++; if (dig_h !== 4'h0) begin n_bad++; $display("FAIL reset_dig_h: got %b expected 0000", dig_h); end
      n_cmp++; if (seg_l !== 8'hFF) begin n_bad++; $display("FAIL reset_seg_l: got %h expected FF", seg_l); end
      n_cmp++; if (dig_l !== 4'hF) begin n_bad++; $display("FAIL reset_dig_l: got %b expected 1111", dig_l); end
      n_cmp++; if (pend_h !== 1'b0 || fd_h !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got pend=%b fd=%b expected 0 0", pend_h, fd_h); end
    end
    rst = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      ed = (((t - 1) % 8) >= 2) ? (4'b0001 << (((t - 1) / 8) % 4)) : 4'b0000;
      es = (ed != 4'b0000) ? 8'h3F : 8'h00;
      n_cmp++; if (dig_h !== ed) begin n_bad++; $display("FAIL scan_dig t=%0d: got %b expected %b", t, dig_h, ed); end
      n_cmp++; if (seg_h !== es) begin n_bad++; $display("FAIL scan_seg t=%0d: got %h expected %h", t, seg_h, es); end
      n_cmp++; if (dig_l !== ~ed || seg_l !== ~es) begin n_bad++; $display("FAIL scan_low t=%0d: got %b/%h expected %b/%h", t, dig_l, seg_l, ~ed, ~es); end
      n_cmp++; if (fd_h !== (t % 32 == 0)) begin n_bad++; $display("FAIL frame_done t=%0d: got %b expected %b", t, fd_h, (t % 32 == 0)); end
    end
  endtask

  task automatic test_double_buffer;
    logic [7:0] exp_seg [4];
    exp_seg = '{8'h71, 8'h77, 8'h5B, 8'h06};
    load_mid_frame(16'h12AF, 4'b0000);
    n_cmp++; if (pend_h !== 1'b1) begin n_bad++; $display("FAIL db_pending_set: got %b expected 1", pend_h); end
    wait_phase(21);
    n_cmp++; if (seg_h !== 8'h3F || pend_h !== 1'b1) begin n_bad++; $display("FAIL db_hold_d2: got %h/%b expected 3F/1", seg_h, pend_h); end
    wait_phase(29);
    n_cmp++; if (seg_h !== 8'h3F || pend_h !== 1'b1) begin n_bad++; $display("FAIL db_hold_d3: got %h/%b expected 3F/1", seg_h, pend_h); end
    wait_phase(0);
    n_cmp++; if (fd_h !== 1'b1 || pend_h !== 1'b0) begin n_bad++; $display("FAIL db_swap: got fd=%b pend=%b expected 1 0", fd_h, pend_h); end
    for (int d = 0; d < 4; d++) begin
      wait_phase(8 * d + 5);
      n_cmp++; if (seg_h !== exp_seg[d]) begin n_bad++; $display("FAIL db_glyph d%0d: got %h expected %h", d, seg_h, exp_seg[d]); end
      n_cmp++; if (dig_h !== (4'b0001 << d)) begin n_bad++; $display("FAIL db_dig d%0d: got %b expected %b", d, dig_h, 4'b0001 << d); end
    end
  endtask

  task automatic test_lzb;
    logic [7:0] exp_a [4];
    logic [7:0] exp_b [4];
    exp_a = '{8'h3F, 8'h6D, 8'h00, 8'h00};
    exp_b = '{8'h3F, 8'h00, 8'h00, 8'h00};
    lzb = 1'b1;
    load_mid_frame(16'h0050, 4'b0000);
    wait_phase(0);
    for (int d = 0; d < 4; d++) begin
      wait_phase(8 * d + 5);
      n_cmp++; if (seg_h !== exp_a[d]) begin n_bad++; $display("FAIL lzb_0050 d%0d: got %h expected %h", d, seg_h, exp_a[d]); end
      n_cmp++; if (dig_h !== (4'b0001 << d)) begin n_bad++; $display("FAIL lzb_dig d%0d: got %b expected %b", d, dig_h, 4'b0001 << d); end
    end
    load_mid_frame(16'h0000, 4'b0000);
    wait_phase(0);
    for (int d = 0; d < 4; d++) begin
      wait_phase(8 * d + 5);
      n_cmp++; if (seg_h !== exp_b[d]) begin n_bad++; $display("FAIL lzb_zero d%0d: got %h expected %h", d, seg_h, exp_b[d]); end
    end
    lzb = 1'b0;
    for (int d = 0; d < 4; d++) begin
      wait_phase(8 * d + 5);
      n_cmp++; if (seg_h !== 8'h3F) begin n_bad++; $display("FAIL lzb_off d%0d: got %h expected 3F", d, seg_h); end
    end
  endtask

  task automatic test_dots;
    logic [7:0] exp_seg [4];
    exp_seg = '{8'h3F, 8'h00, 8'h80, 8'h00};
    lzb = 1'b1;
    load_mid_frame(16'h0000, 4'b0100);
    wait_phase(0);
    for (int d = 0; d < 4; d++) begin
      wait_phase(8 * d + 5);
      n_cmp++; if (seg_h !== exp_seg[d]) begin n_bad++; $display("FAIL dots d%0d: got %h expected %h", d, seg_h, exp_seg[d]); end
    end
    lzb = 1'b0;
    dots = 4'b0000;
  endtask

  task automatic test_swap_collision;
    load_mid_frame(16'h1111, 4'b0000);
    value = 16'h2222;
    wait_phase(31);
    n_cmp++; if (pend_h !== 1'b1) begin n_bad++; $display("FAIL swap_pending_before: got %b expected 1", pend_h); end
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n_cmp++; if (fd_h !== 1'b1 || pend_h !== 1'b0) begin n_bad++; $display("FAIL swap_wrap: got fd=%b pend=%b expected 1 0", fd_h, pend_h); end
    for (int d = 0; d < 4; d++) begin
      wait_phase(8 * d + 5);
      n_cmp++; if (seg_h !== 8'h5B) begin n_bad++; $display("FAIL swap_glyph d%0d: got %h expected 5B", d, seg_h); end
    end
    n_cmp++; if (pend_h !== 1'b0) begin n_bad++; $display("FAIL swap_pending_after: got %b expected 0", pend_h); end
  endtask

  task automatic test_polarity_reset;
    load_mid_frame(16'h3333, 4'b0000);
    wait_phase(21);
    n_cmp++; if (seg_l !== 8'hA4 || dig_l !== 4'b1011) begin n_bad++; $display("FAIL pol_d2: got %h/%b expected A4/1011", seg_l, dig_l); end
    n_cmp++; if (pend_l !== 1'b1) begin n_bad++; $display("FAIL pol_pending: got %b expected 1", pend_l); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (seg_l !== 8'hFF || dig_l !== 4'hF) begin n_bad++; $display("FAIL midrst_low: got %h/%b expected FF/1111", seg_l, dig_l); end
    n_cmp++; if (seg_h !== 8'h00 || dig_h !== 4'h0) begin n_bad++; $display("FAIL midrst_high: got %h/%b expected 00/0000", seg_h, dig_h); end
    n_cmp++; if (pend_l !== 1'b0 || fd_l !== 1'b0) begin n_bad++; $display("FAIL midrst_flags: got pend=%b fd=%b expected 0 0", pend_l, fd_l); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (seg_l !== 8'hC0 || dig_l !== 4'b1110) begin n_bad++; $display("FAIL postrst_d0: got %h/%b expected C0/1110", seg_l, dig_l); end
    n_cmp++; if (seg_h !== 8'h3F) begin n_bad++; $display("FAIL postrst_d0_high: got %h expected 3F", seg_h); end
    wait_phase(13);
    n_cmp++; if (seg_l !== 8'hC0 || dig_l !== 4'b1101) begin n_bad++; $display("FAIL postrst_d1: got %h/%b expected C0/1101", seg_l, dig_l); end
    wait_phase(0);
    wait_phase(5);
    n_cmp++; if (seg_l !== 8'hC0 || pend_l !== 1'b0) begin n_bad++; $display("FAIL shadow_discard: got %h/%b expected C0/0", seg_l, pend_l); end
  endtask

`ifdef SEG7_DIMMING_EN
  task automatic test_dimming;
    int lit;
    lit = 0;
    bright = 3'd3;
    wait_phase(8);
    repeat (8) begin
      @(negedge clk);
      if (dig_h != 4'b0000) lit++;
    end
    n_cmp++; if (lit != 3) begin n_bad++; $display("FAIL dim_bright3: got %0d lit cycles expected 3", lit); end
    bright = 3'd7;
  endtask
`endif

  initial begin
    test_reset();
    test_double_buffer();
    test_lzb();
    test_dots();
    test_swap_collision();
    test_polarity_reset();
`ifdef SEG7_DIMMING_EN
    test_dimming();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Multiplexed N-digit 7-segment display driver for the board's LED display modules, such as the TM1638 front panel and direct-drive common-cathode/anode digits. It holds a double-buffered N-nibble hex value and scans one digit per time slot, driving a one-hot digit enable and that digit's segment pattern.
- Adds tear-free frame-boundary update, leading-zero blanking, anti-ghosting blank time and selectable output polarity.
- Sits between application counters/registers and the display pins or serial shifter.

Parameters:
- NUM_DIGITS, 8: digits scanned; range 1..16.
- CLK_DIV, 1000: CLK cycles per digit slot; must be ≥ 4.
- BLANK_CYC, 2: cycles at the start of each slot with all outputs inactive; must be < CLK_DIV.
- SEG_ACT_LOW, 0: 1 = SEG outputs active-low.
- DIG_ACT_LOW, 0: 1 = DIG outputs active-low.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset; synchronous and active-high, sampled on rising CLK.
- VALUE  in  4*NUM_DIGITS  hex value; nibble i drives digit i; digit 0 is least significant.
- DOTS  in  NUM_DIGITS  decimal point per digit.
- LOAD  in  1  one-cycle strobe that captures VALUE/DOTS into the shadow buffer.
- LZB  in  1  leading-zero blanking enable; level input, applied live.
- SEG  out  8  segment drive: bit0=a .. bit6=g, bit7=dp.
- DIG  out  NUM_DIGITS  one-hot digit enable.
- PENDING  out  1  shadow holds data not yet displayed.
- FRAME_DONE  out  1  one-cycle pulse at frame wrap.

Behaviour:
- Reset values (next edge after RST=1):
  - div_cnt=0, dig_idx=0, active=0, shadow=0, PENDING=0, FRAME_DONE=0.
  - SEG and DIG at their inactive level: all 0, or all 1 for the active-low variants.
- Prescaler:
  - div_cnt counts 0..CLK_DIV-1, then wraps.
  - tick = (div_cnt==CLK_DIV-1).
  - On tick, dig_idx increments; it wraps from NUM_DIGITS-1 to 0.
- FRAME_DONE is asserted the cycle after a tick with dig_idx==NUM_DIGITS-1, which is the same cycle dig_idx shows 0.
- Buffering:
  - LOAD=1: shadow <= {VALUE, DOTS} and PENDING <= 1.
  - A second LOAD before the swap overwrites the shadow; last write wins.
  - Swap on the frame-wrap tick: if PENDING, active <= shadow and PENDING <= 0.
  - LOAD in the same cycle as the swap tick: the new VALUE/DOTS go straight to active, and PENDING ends at 0.
  - Active data never changes mid-frame.
- Glyphs:
  - Standard hex font: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
  - Values are active-high, bits [6:0].
  - dp = active DOTS[i].
- Leading-zero blanking:
  - When LZB=1, digit i>0 is blanked (bits [6:0]=0) if active nibbles NUM_DIGITS-1..i are all zero.
  - Digit 0 is never blanked.
  - dp is unaffected by blanking.
- Output window:
  - SEG/DIG are registered, one cycle after (div_cnt, dig_idx).
  - They are inactive while div_cnt < BLANK_CYC.
  - Otherwise DIG = one-hot(dig_idx) and SEG = glyph of digit dig_idx.
  - Polarity inversion per SEG_ACT_LOW/DIG_ACT_LOW is applied last.
- At most one DIG bit is active in any cycle; there is always at least one inactive cycle between two digits.
- RST mid-frame: everything returns to reset values next cycle, and any pending shadow is discarded.

Optional Feature:
- Macro: SEG7_DIMMING_EN.
- When defined:
  - Extra input BRIGHT [2:0].
  - The active window shrinks to div_cnt in [BLANK_CYC, BLANK_CYC + ((CLK_DIV-BLANK_CYC)*(BRIGHT+1))/8).
  - BRIGHT=7 equals the full window; the integer product is evaluated at width ≥ 16 bits.
  - BRIGHT is sampled live each cycle.
- When undefined: no BRIGHT port, and the window is always the full window.

Decomposition:
- Package seg7_pkg:
  - 16-entry glyph constant array.
  - SEG_OFF constant.
  - Segment bit-index localparams (SEG_A..SEG_G, SEG_DP).
  - clog2-based width helpers for div_cnt and dig_idx.
- Sub-module seg7_glyph_lut: combinational nibble + blank + dp → 8-bit active-high pattern.
- The scan counters, buffering and output registers stay in seg7_scan_driver.

Test Plan:
All scenarios use NUM_DIGITS=4, CLK_DIV=8, BLANK_CYC=2.
1. Reset/scan:
   - Stimulus: RST high 3 cycles, then low.
   - Response: SEG=00 and DIG=0 while in reset. DIG first goes 0001 on the 3rd cycle after release, stays 6 cycles, then is 0 for 2 cycles, then 0010. FRAME_DONE pulses every 32 cycles.
2. Double buffer:
   - Stimulus: LOAD VALUE=16'h12AF at cycle 5 of digit 1.
   - Response: PENDING=1 and displayed glyphs stay 3F until FRAME_DONE. The next frame shows d0=71, d1=77, d2=5B, d3=06, and PENDING=0.
3. LZB:
   - Stimulus: LZB=1, VALUE=16'h0050 loaded.
   - Response: d3=00, d2=00, d1=6D, d0=3F. With VALUE=0, only d0=3F is lit; with LZB=0, all four digits show 3F.
4. Dots:
   - Stimulus: DOTS=4'b0100, LZB=1, VALUE=0.
   - Response: d2 SEG=80 (blanked glyph, dp on); the others have SEG[7]=0.
5. Swap collision:
   - Stimulus: LOAD 16'h1111 mid-frame, then LOAD 16'h2222 exactly on the wrap tick.
   - Response: the next frame shows all 5B, never 06, and PENDING=0.
6. Polarity/reset mid-frame:
   - Stimulus: SEG_ACT_LOW=1, DIG_ACT_LOW=1 build; assert RST during digit 2 with PENDING=1.
   - Response: SEG=FF and DIG=F next cycle, PENDING=0, old active data is gone (d0 shows C0 after release).
   - With SEG7_DIMMING_EN and BRIGHT=3: 3 active cycles per slot.
